stream_buffer_ctrl: RTL and testbench
=====================================

Name: stream_buffer_ctrl

Overview:
Parametrised capture-and-replay buffer for byte streams terminated by a sentinel character. Generalises the single-mode people-stream FIFO path in CIPU: one block serves the FIFO, LIFO and FIFO2 output channels, selected per transaction by a mode input. It owns storage, the handshake FSM and the done signalling. CIPU instantiates it once per output channel.

Parameters:
DATA_W, 8, data width in bits
DEPTH, 16, storage entries (power of two, at least 2)
TERM, 8'h24, terminator value ('$'); never stored
CNT_W, $clog2(DEPTH)+1, width of the occupancy count

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset
ready  input  1  downstream ready; also starts a transaction from IDLE
mode  input  1  0 = FIFO order, 1 = LIFO order; sampled at IDLE->FILL
in_valid  input  1  data_in is meaningful this cycle
data_in  input  DATA_W  stream byte
valid  output  1  data_out is a valid popped entry this cycle
data_out  output  DATA_W  popped entry
done  output  1  one-cycle pulse: transaction complete
overflow  output  1  sticky: a byte was dropped because storage was full
count  output  CNT_W  current occupancy

Behaviour:
- Reset (rst low, asynchronous): state IDLE; valid=0, done=0, overflow=0, count=0, data_out=0; read/write pointers 0. Storage contents are don't-care. Reset mid-transaction aborts it with no done pulse.
- All outputs are registered. data_out holds its last value while valid=0.
- States: IDLE, FILL, DRAIN, DONE.
- IDLE:
  - ready=1 -> FILL next cycle.
  - Latch mode; clear overflow; pointers and count 0.
  - data_in is ignored in IDLE.
- FILL (samples data_in on every edge where in_valid=1):
  - data_in==TERM -> not stored. Go to DRAIN if count>0, else DONE.
  - data_in!=TERM and count<DEPTH -> write at wr_ptr; wr_ptr++ (wraps mod DEPTH); count++.
  - data_in!=TERM and count==DEPTH -> byte dropped; overflow<=1; count unchanged.
  - in_valid=0 -> no change (stall).
- DRAIN (ready=1 and count>0 on an edge pops one entry):
  - FIFO mode: entry at rd_ptr; rd_ptr++ with wrap.
  - LIFO mode: entry at wr_ptr-1; wr_ptr--.
  - On the pop: data_out<=entry, valid<=1, count--.
  - ready=0: valid<=0, nothing popped. Bubbles are allowed.
  - count==0 -> DONE, valid<=0.
  - Latency: data appears the cycle after the ready edge. Max throughput is 1 entry/cycle.
- DONE: done=1 for exactly one cycle; then IDLE. overflow holds until the next IDLE->FILL.
- FILL stores only; DRAIN pops only. There is no simultaneous read and write.
- Mode changes outside IDLE have no effect.
- count always equals entries stored minus entries popped, and is at most DEPTH.
- Pointer wrap: wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap naturally.
- A FIFO fill of exactly DEPTH bytes followed by a full drain must return all DEPTH bytes in order.

Test Plan:
- FIFO basic: mode=0, ready pulse, stream "ABC$", ready held 1 -> valid high 3 consecutive cycles with 'A','B','C'; done 1 cycle later; count 3->0.
- LIFO basic: mode=1, stream "ABC$" -> outputs 'C','B','A'; done pulse; overflow=0.
- Overflow: DEPTH=16, stream 20 bytes 0x01..0x14 then '$' -> count=16, overflow=1, FIFO drain outputs 0x01..0x10, done; overflow clears on the next start.
- Empty stream: start then '$' immediately -> no valid, done asserted the cycle after DRAIN would be entered (FILL->DONE), count stays 0.
- Backpressure/stalls: in_valid toggled with in_valid=0 gaps during FILL; ready toggled 1,0,0,1,... during DRAIN -> one entry per ready-high edge, no loss or duplication, order preserved.
- Async reset mid-DRAIN: drop rst between clock edges after 2 of 5 pops -> valid/done/count/overflow go 0 immediately. The next transaction "XY$" returns 'X','Y' correctly.

Source files
------------

// File: rtl/stream_buffer_ctrl_if.sv
// stream_buffer_ctrl_if: handshake and data bundle between a stream source/sink and the buffer
interface stream_buffer_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 5
);
    logic              ready;
    logic              mode;
    logic              in_valid;
    logic [DATA_W-1:0] data_in;
    logic              valid;
    logic [DATA_W-1:0] data_out;
    logic              done;
    logic              overflow;
    logic [CNT_W-1:0]  count;

    modport master (
        output ready, mode, in_valid, data_in,
        input  valid, data_out, done, overflow, count
    );

    modport slave (
        input  ready, mode, in_valid, data_in,
        output valid, data_out, done, overflow, count
    );
endinterface

// File: rtl/stream_buffer_ctrl.sv
// stream_buffer_ctrl: capture a terminated byte stream, then replay it in FIFO or LIFO order
module stream_buffer_ctrl #(
    parameter int                DATA_W = 8,
    parameter int                DEPTH  = 16,
    parameter logic [DATA_W-1:0] TERM   = 8'h24,
    parameter int                CNT_W  = $clog2(DEPTH) + 1
) (
    input logic                clk,
    input logic                rst,
    stream_buffer_ctrl_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

    state_t            state_q;
    logic              mode_q;
    logic              valid_q;
    logic              done_q;
    logic              overflow_q;
    logic [DATA_W-1:0] data_out_q;
    logic [CNT_W-1:0]  count_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic             is_term;
    logic             full;
    logic             wr_en;
    logic [PTR_W-1:0] pop_idx;

    assign is_term = bus.data_in == TERM;
    assign full    = count_q == FULL;
    assign wr_en   = state_q == FILL && bus.in_valid && !is_term && !full;
    assign pop_idx = mode_q ? wr_ptr_q - PTR_W'(1) : rd_ptr_q;

    assign bus.valid    = valid_q;
    assign bus.data_out = data_out_q;
    assign bus.done     = done_q;
    assign bus.overflow = overflow_q;
    assign bus.count    = count_q;

    // storage write; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= bus.data_in;
    end

    // transaction FSM with registered outputs: IDLE -> FILL -> (DRAIN) -> DONE -> IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            data_out_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q  <= 1'b0;
                    done_q   <= 1'b0;
                    count_q  <= '0;
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    if (bus.ready) begin
                        mode_q     <= bus.mode;
                        overflow_q <= 1'b0;
                        state_q    <= FILL;
                    end
                end
                FILL: begin
                    if (bus.in_valid) begin
                        if (is_term) begin
                            state_q <= |count_q ? DRAIN : DONE;
                            done_q  <= ~|count_q;
                        end else if (!full) begin
                            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                            count_q  <= count_q + CNT_W'(1);
                        end else begin
                            overflow_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!(|count_q)) begin
                        state_q <= DONE;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (bus.ready) begin
                        data_out_q <= mem_q[pop_idx];
                        valid_q    <= 1'b1;
                        count_q    <= count_q - CNT_W'(1);
                        if (mode_q) wr_ptr_q <= wr_ptr_q - PTR_W'(1);
                        else        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stream_buffer_ctrl.sv
// tb_stream_buffer_ctrl: directed scoreboard bench for stream_buffer_ctrl
module tb_stream_buffer_ctrl;
    localparam int DEPTH = 16;
    localparam logic [7:0] TERM = 8'h24;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   npop  = 0;
    int   ndone = 0;
    int   mcnt  = 0;
    bit   lifo  = 1'b0;
    logic done_prev = 1'b0;
    logic [7:0] exp_q[$];

    stream_buffer_ctrl_if #(.DATA_W(8), .CNT_W(5)) bus ();

    stream_buffer_ctrl #(.DATA_W(8), .DEPTH(DEPTH), .TERM(TERM)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // monitor: pop scoreboard on every valid beat, track done pulses
    always @(posedge clk) begin
        #1;
        if (bus.valid === 1'b1) begin
            npop++;
            check("valid_needs_ready", {31'd0, bus.ready}, 32'd1);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_pop observed=%0h expected=none", bus.data_out);
            end else begin
                check("data_out", {24'd0, bus.data_out}, {24'd0, exp_q.pop_front()});
            end
        end
        if (bus.done === 1'b1) begin
            ndone++;
            check("done_one_cycle", {31'd0, done_prev}, 32'd0);
        end
        done_prev = bus.done;
    end

    task automatic start(input bit m);
        lifo = m;
        mcnt = 0;
        bus.mode  = m;
        bus.ready = 1'b1;
        @(negedge clk);
        bus.ready = 1'b0;
        bus.mode  = ~m;
    endtask

    task automatic send(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.data_in  = b;
        if (b != TERM && mcnt < DEPTH) begin
            if (lifo) exp_q.push_front(b);
            else      exp_q.push_back(b);
            mcnt++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic gap();
        bus.in_valid = 1'b0;
        bus.data_in  = TERM;
        @(negedge clk);
    endtask

    task automatic drain(input logic [3:0] pat, input string tag);
        int d0;
        bit got;
        d0  = ndone;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            bus.ready = pat[i % 4];
            @(negedge clk);
            if (ndone != d0) begin
                got = 1'b1;
                break;
            end
        end
        bus.ready = 1'b0;
        check({tag, "_done"}, {31'd0, got}, 32'd1);
        check({tag, "_leftover"}, exp_q.size(), 32'd0);
        check({tag, "_count_end"}, {27'd0, bus.count}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        bus.ready    = 1'b0;
        bus.mode     = 1'b0;
        bus.in_valid = 1'b0;
        bus.data_in  = 8'h00;
        #12;
        check("rst_valid", {31'd0, bus.valid}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
        check("rst_count", {27'd0, bus.count}, 32'd0);
        check("rst_data_out", {24'd0, bus.data_out}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        start(1'b0);
        send("A"); send("B"); send("C"); send(TERM);
        check("fifo_count", {27'd0, bus.count}, 32'd3);
        drain(4'b1111, "fifo");

        start(1'b1);
        send("A"); send("B"); send("C"); send(TERM);
        drain(4'b1111, "lifo");
        check("lifo_overflow", {31'd0, bus.overflow}, 32'd0);

        start(1'b0);
        for (int i = 1; i <= 20; i++) send(8'(i));
        send(TERM);
        check("ovf_count", {27'd0, bus.count}, 32'd16);
        check("ovf_flag", {31'd0, bus.overflow}, 32'd1);
        drain(4'b1111, "ovf");
        check("ovf_held", {31'd0, bus.overflow}, 32'd1);

        start(1'b0);
        check("ovf_cleared", {31'd0, bus.overflow}, 32'd0);
        base = ndone;
        send(TERM);
        check("empty_done", {31'd0, bus.done}, 32'd1);
        check("empty_valid", {31'd0, bus.valid}, 32'd0);
        check("empty_count", {27'd0, bus.count}, 32'd0);
        @(negedge clk);
        check("empty_done_seen", ndone - base, 32'd1);
        check("empty_done_drop", {31'd0, bus.done}, 32'd0);

        start(1'b0);
        send("a"); gap(); send("b"); gap(); gap(); send("c"); send("d"); gap(); send("e"); send(TERM);
        check("bp_count", {27'd0, bus.count}, 32'd5);
        drain(4'b1001, "bp");

        start(1'b0);
        for (int i = 0; i < 5; i++) send(8'h11 + 8'(i));
        send(TERM);
        base = npop;
        bus.ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (npop - base >= 2) break;
        end
        check("pops_before_reset", npop - base, 32'd2);
        check("pre_reset_count", {27'd0, bus.count}, 32'd3);
        rst = 1'b0;
        #1;
        check("arst_valid", {31'd0, bus.valid}, 32'd0);
        check("arst_done", {31'd0, bus.done}, 32'd0);
        check("arst_count", {27'd0, bus.count}, 32'd0);
        check("arst_overflow", {31'd0, bus.overflow}, 32'd0);
        exp_q.delete();
        bus.ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        start(1'b0);
        send("X"); send("Y"); send(TERM);
        drain(4'b1111, "xy");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
